// File: rtl/vga_timing_pkg.sv
// Shared types, defaults and span arithmetic for the parametrised VGA timing generator.
package vga_timing_pkg;

  localparam int COORD_W = 16;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;

  typedef struct packed {
    int total;
    int vis_first;
    int vis_end;
  } span_t;

  typedef struct packed {
    logic               hs;
    logic               vs;
    logic               vis;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic               line_start;
    logic               frame_start;
    logic               vblank;
  } sync_bundle_t;

  // Period order is sync, back porch, active, front porch.
  function automatic span_t calc_span(input int sync, input int back,
                                      input int active, input int front);
    span_t s;
    s.total     = sync + back + active + front;
    s.vis_first = sync + back;
    s.vis_end   = sync + back + active;
    return s;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-qualified shift register of DEPTH stages; DEPTH = 0 is a plain wire.
module vga_sync_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    logic unused_ctl;
    assign unused_ctl = clk ^ rst_n ^ en;
    assign q = d;
  end else begin : g_sr
    logic [DEPTH-1:0][W-1:0] sr;

    // NOTE: every stage is reset so HS/VS come out inactive while reset_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sr <= '0;
      end else if (en) begin
        // NOTE: non-blocking assignment makes each stage take the pre-edge value of its neighbour.
        sr[0] <= d;
        for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with clock enable and output delay line.
// Optional genlock input ext_vs is enabled by defining VGA_TIMING_GENLOCK_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int PIPE_DLY = 0,
  parameter int XW       = 11,
  parameter int YW       = 10
) (
  input  logic          vga_clk,
  input  logic          reset_n,
  input  logic          clk_en,
`ifdef VGA_TIMING_GENLOCK_EN
  input  logic          ext_vs,
`endif
  output logic          HS,
  output logic          VS,
  output logic          blank_n,
  output logic [XW-1:0] xPos,
  output logic [YW-1:0] yPos,
  output logic          line_start,
  output logic          frame_start,
  output logic          vblank_irq,
  output logic [7:0]    frame_cnt
);

  localparam span_t H_SPAN = calc_span(H_SYNC, H_BACK, H_ACTIVE, H_FRONT);
  localparam span_t V_SPAN = calc_span(V_SYNC, V_BACK, V_ACTIVE, V_FRONT);

  if (H_SPAN.total > (1 << XW) || XW > COORD_W) begin : g_bad_h
    $error("vga_timing_gen: horizontal total does not fit XW");
  end
  if (V_SPAN.total > (1 << YW) || YW > COORD_W) begin : g_bad_v
    $error("vga_timing_gen: vertical total does not fit YW");
  end
  if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
    $error("vga_timing_gen: PIPE_DLY must be 0..7");
  end

  localparam logic [XW-1:0] H_LAST      = XW'(H_SPAN.total - 1);
  localparam logic [XW-1:0] H_SYNC_END  = XW'(H_SYNC);
  localparam logic [XW-1:0] H_VIS_FIRST = XW'(H_SPAN.vis_first);
  localparam logic [XW-1:0] H_VIS_LAST  = XW'(H_SPAN.vis_end - 1);
  localparam logic [YW-1:0] V_LAST      = YW'(V_SPAN.total - 1);
  localparam logic [YW-1:0] V_SYNC_END  = YW'(V_SYNC);
  localparam logic [YW-1:0] V_VIS_FIRST = YW'(V_SPAN.vis_first);
  localparam logic [YW-1:0] V_VIS_LAST  = YW'(V_SPAN.vis_end - 1);
  localparam logic [YW-1:0] V_IRQ_LINE  = YW'(V_SPAN.vis_end);
  localparam logic          HAS_IRQ     = (V_SPAN.vis_end < V_SPAN.total);
  localparam logic          HS_ACT      = (HS_POL != 0);
  localparam logic          VS_ACT      = (VS_POL != 0);

  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic          restart;

`ifdef VGA_TIMING_GENLOCK_EN
  logic [2:0] ext_sync;
  logic       ext_rise;
  logic       gl_pend;

  // Two synchroniser flops, third flop is edge history; edge is held until the next enabled cycle.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_sync <= '0;
      gl_pend  <= 1'b0;
    end else begin
      ext_sync <= {ext_sync[1:0], ext_vs};
      if (clk_en)        gl_pend <= 1'b0;
      else if (ext_rise) gl_pend <= 1'b1;
    end
  end

  assign ext_rise = ext_sync[1] & ~ext_sync[2];
  assign restart  = (gl_pend | ext_rise) & ~((h_cnt == '0) && (v_cnt == '0));
`else
  assign restart = 1'b0;
`endif

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (clk_en) begin
      if (restart) begin
        h_cnt <= '0;
        v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  sync_bundle_t dec, stage0, fin;
  logic         h_vis, v_vis;

  always_comb begin
    // NOTE: assigning a default first keeps every field driven on all paths, so no latch.
    dec             = '0;
    h_vis           = (h_cnt >= H_VIS_FIRST) && (h_cnt <= H_VIS_LAST);
    v_vis           = (v_cnt >= V_VIS_FIRST) && (v_cnt <= V_VIS_LAST);
    dec.hs          = (h_cnt < H_SYNC_END);
    dec.vs          = (v_cnt < V_SYNC_END);
    dec.vis         = h_vis && v_vis;
    dec.x           = h_vis ? COORD_W'(h_cnt - H_VIS_FIRST) : '0;
    dec.y           = v_vis ? COORD_W'(v_cnt - V_VIS_FIRST) : '0;
    dec.line_start  = (h_cnt == '0);
    dec.frame_start = (h_cnt == '0) && (v_cnt == '0);
    dec.vblank      = HAS_IRQ && (h_cnt == '0) && (v_cnt == V_IRQ_LINE);
  end

  logic en_q;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      stage0    <= '0;
      en_q      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      en_q <= clk_en;
      if (clk_en) stage0 <= dec;
      if (clk_en && fin.frame_start) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  vga_sync_delay #(
    .W     ($bits(sync_bundle_t)),
    .DEPTH (PIPE_DLY)
  ) u_delay (
    .clk   (vga_clk),
    .rst_n (reset_n),
    .en    (clk_en),
    .d     (stage0),
    .q     (fin)
  );

  // Strobes are gated by the registered enable so they last one vga_clk cycle at any duty.
  assign HS          = fin.hs ? HS_ACT : ~HS_ACT;
  assign VS          = fin.vs ? VS_ACT : ~VS_ACT;
  assign blank_n     = fin.vis;
  assign xPos        = fin.x[XW-1:0];
  assign yPos        = fin.y[YW-1:0];
  assign line_start  = fin.line_start & en_q;
  assign frame_start = fin.frame_start & en_q;
  assign vblank_irq  = fin.vblank & en_q;

  logic unused_coord;
  assign unused_coord = ^{fin.x, fin.y};

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench on a 12x8 miniature raster: one PIPE_DLY=0 instance, one PIPE_DLY=3 inverted-polarity instance.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic clk_en = 1'b1;
`ifdef VGA_TIMING_GENLOCK_EN
  logic ext_vs = 1'b0;
`endif

  logic       hs_a, vs_a, bl_a, ls_a, fs_a, vb_a;
  logic [3:0] xa;
  logic [2:0] ya;
  logic [7:0] fc_a;
  logic       hs_b, vs_b, bl_b, ls_b, fs_b, vb_b;
  logic [3:0] xb;
  logic [2:0] yb;
  logic [7:0] fc_b;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(6), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(3), .V_FRONT(2), .V_SYNC(1), .V_BACK(2),
    .HS_POL(0), .VS_POL(0), .PIPE_DLY(0), .XW(4), .YW(3)
  ) dut_a (
    .vga_clk(clk), .reset_n(reset_n), .clk_en(clk_en),
`ifdef VGA_TIMING_GENLOCK_EN
    .ext_vs(ext_vs),
`endif
    .HS(hs_a), .VS(vs_a), .blank_n(bl_a), .xPos(xa), .yPos(ya),
    .line_start(ls_a), .frame_start(fs_a), .vblank_irq(vb_a), .frame_cnt(fc_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(6), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_ACTIVE(3), .V_FRONT(2), .V_SYNC(1), .V_BACK(2),
    .HS_POL(1), .VS_POL(1), .PIPE_DLY(3), .XW(4), .YW(3)
  ) dut_b (
    .vga_clk(clk), .reset_n(reset_n), .clk_en(clk_en),
`ifdef VGA_TIMING_GENLOCK_EN
    .ext_vs(ext_vs),
`endif
    .HS(hs_b), .VS(vs_b), .blank_n(bl_b), .xPos(xb), .yPos(yb),
    .line_start(ls_b), .frame_start(fs_b), .vblank_irq(vb_b), .frame_cnt(fc_b)
  );

  int checks = 0;
  int errors = 0;
  int k = 0;
  bit hist_on = 1'b0;
  bit toggle = 1'b0;
  logic [31:0] hist [0:255];
  int cnt_hs_low, cnt_vs_low, cnt_fs, cnt_ls, cnt_vb, cnt_vis, wide;
  logic prev_ls, prev_fs, prev_vb;

  logic [31:0] vec_a, vec_b_norm;
  assign vec_a      = {11'd0, hs_a, vs_a, bl_a, xa, ya, ls_a, fs_a, vb_a, fc_a};
  assign vec_b_norm = {11'd0, ~hs_b, ~vs_b, bl_b, xb, yb, ls_b, fs_b, vb_b, fc_b};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_counts();
    cnt_hs_low = 0; cnt_vs_low = 0; cnt_fs = 0; cnt_ls = 0; cnt_vb = 0; cnt_vis = 0;
    wide = 0; prev_ls = 1'b0; prev_fs = 1'b0; prev_vb = 1'b0;
  endtask

  // One vga_clk cycle; outputs are observed on the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    k++;
    if (hs_a === 1'b0) cnt_hs_low++;
    if (vs_a === 1'b0) cnt_vs_low++;
    if (fs_a === 1'b1) cnt_fs++;
    if (ls_a === 1'b1) cnt_ls++;
    if (vb_a === 1'b1) cnt_vb++;
    if (bl_a === 1'b1) cnt_vis++;
    if ((prev_ls & ls_a) | (prev_fs & fs_a) | (prev_vb & vb_a)) wide++;
    prev_ls = ls_a; prev_fs = fs_a; prev_vb = vb_a;
    if (hist_on && k >= 4 && k < 256) check("pipe3_shift", vec_b_norm, hist[k-3]);
    if (k < 256) hist[k] = vec_a;
    if (toggle) clk_en = ~clk_en;
  endtask

  // Full-rate phase: after tick k the outputs of dut_a show counter index k-1.
  task automatic run_to(input int n);
    while (k < n + 1) tick();
  endtask

  initial begin
    bit found;
    int lat;
    clear_counts();
    repeat (3) @(negedge clk);
    check("rst_hs", hs_a, 1);
    check("rst_vs", vs_a, 1);
    check("rst_blank", bl_a, 0);
    check("rst_x", xa, 0);
    check("rst_y", ya, 0);
    check("rst_fs", fs_a, 0);
    check("rst_ls", ls_a, 0);
    check("rst_vb", vb_a, 0);
    check("rst_fc", fc_a, 0);
    check("rst_hs_b", hs_b, 0);
    check("rst_vs_b", vs_b, 0);

    reset_n = 1'b1;
    k = 0;
    hist_on = 1'b1;
    run_to(0);
    check("n0_fs", fs_a, 1);
    check("n0_ls", ls_a, 1);
    check("n0_hs", hs_a, 0);
    check("n0_vs", vs_a, 0);
    check("n0_blank", bl_a, 0);
    check("n0_fc", fc_a, 0);
    run_to(1);
    check("n1_fs", fs_a, 0);
    check("n1_ls", ls_a, 0);
    check("n1_hs", hs_a, 0);
    check("n1_fc", fc_a, 1);
    run_to(2);
    check("n2_hs", hs_a, 1);
    run_to(12);
    check("n12_ls", ls_a, 1);
    check("n12_fs", fs_a, 0);
    check("n12_vs", vs_a, 1);
    check("n12_hs", hs_a, 0);
    run_to(40);
    check("first_vis_blank", bl_a, 1);
    check("first_vis_x", xa, 0);
    check("first_vis_y", ya, 0);
    run_to(45);
    check("last_px_x", xa, 5);
    check("last_px_blank", bl_a, 1);
    run_to(46);
    check("front_blank", bl_a, 0);
    check("front_x", xa, 0);
    run_to(69);
    check("last_line_x", xa, 5);
    check("last_line_y", ya, 2);
    run_to(72);
    check("vblank_on", vb_a, 1);
    check("vblank_blank", bl_a, 0);
    check("vblank_y", ya, 0);
    run_to(73);
    check("vblank_off", vb_a, 0);
    run_to(95);
    check("frame_hs_low", cnt_hs_low, 16);
    check("frame_vs_low", cnt_vs_low, 12);
    check("frame_fs_cnt", cnt_fs, 1);
    check("frame_ls_cnt", cnt_ls, 8);
    check("frame_vb_cnt", cnt_vb, 1);
    check("frame_vis_cnt", cnt_vis, 18);
    check("frame_wide", wide, 0);
    run_to(96);
    check("fs_period", fs_a, 1);
    check("fc_before_inc", fc_a, 1);
    run_to(97);
    check("fc_after_inc", fc_a, 2);
    run_to(100);
    hist_on = 1'b0;

    run_to(132);
    check("pre_stall_ls", ls_a, 1);
    check("pre_stall_hs", hs_a, 0);
    clk_en = 1'b0;
    repeat (5) tick();
    check("stall_ls", ls_a, 0);
    check("stall_hs", hs_a, 0);
    check("stall_vs", vs_a, 1);
    check("stall_fc", fc_a, 2);
    clk_en = 1'b1;
    tick();
    check("resume_ls", ls_a, 0);
    check("resume_hs", hs_a, 0);
    tick();
    check("resume_hs_end", hs_a, 1);
    repeat (4) tick();
    check("pre_rst_blank", bl_a, 1);
    check("pre_rst_x", xa, 2);

    #2 reset_n = 1'b0;
    #1;
    check("async_rst_hs", hs_a, 1);
    check("async_rst_blank", bl_a, 0);
    check("async_rst_x", xa, 0);
    check("async_rst_fc", fc_a, 0);
    check("async_rst_hs_b", hs_b, 0);
    check("async_rst_vs_b", vs_b, 0);
    @(negedge clk);
    @(negedge clk);

    clear_counts();
    k = 0;
    toggle = 1'b1;
    clk_en = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 48963; i++) begin
      tick();
      case (k)
        1:     begin check("tg_k1_fs", fs_a, 1); check("tg_k1_hs", hs_a, 0); check("tg_k1_fc", fc_a, 0); end
        2:     begin check("tg_k2_fs", fs_a, 0); check("tg_k2_hs", hs_a, 0); check("tg_k2_fc", fc_a, 0); end
        3:     begin check("tg_k3_fc", fc_a, 1); check("tg_k3_fs", fs_a, 0); end
        4:     check("tg_k4_hs", hs_a, 0);
        5:     check("tg_k5_hs", hs_a, 1);
        193:   begin check("tg_fs_period", fs_a, 1); check("tg_k193_fc", fc_a, 1); end
        194:   check("tg_k194_fs", fs_a, 0);
        195:   check("tg_k195_fc", fc_a, 2);
        48962: check("tg_fc_255", fc_a, 255);
        48963: check("tg_fc_wrap", fc_a, 0);
        default: ;
      endcase
    end
    check("tg_fs_cnt", cnt_fs, 256);
    check("tg_ls_cnt", cnt_ls, 2041);
    check("tg_wide", wide, 0);
    toggle = 1'b0;

`ifdef VGA_TIMING_GENLOCK_EN
    reset_n = 1'b0;
    clk_en = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    k = 0;
    run_to(63);
    check("gl_pre_fc", fc_a, 1);
    check("gl_pre_y", ya, 2);
    ext_vs = 1'b1;
    found = 1'b0;
    lat = 0;
    for (int i = 1; i <= 4 && !found; i++) begin
      tick();
      if (fs_a === 1'b1) begin
        found = 1'b1;
        lat = i;
      end
    end
    check("gl_fs_seen", found, 1);
    check("gl_latency", lat, 4);
    tick();
    check("gl_fc", fc_a, 2);
    check("gl_hs", hs_a, 0);
    ext_vs = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
